// File: rtl/dm_arbiter_if.sv
// -----------------------------------------------------------------------------
// dm_arbiter_if
// Bundles the two requester ports (sorter S, debug unit D) and the data-memory
// port of the dm_arbiter.
//
// Handshake: a requester raises x_req (with x_we/x_addr/x_wdata valid) and
// keeps it high for the whole burst. An access happens in every cycle where
// x_req and x_gnt are both high. Requests while x_gnt is low are ignored
// rather than queued. Read data returns one cycle after the access as a
// single-cycle x_rvalid pulse with x_rdata; writes return nothing.
//
// Modports
//   master : requesters plus memory model (drive req/we/addr/wdata, m_rdata)
//   slave  : the arbiter (drives gnt/rvalid/rdata and the memory bus)
// -----------------------------------------------------------------------------
interface dm_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 32
);
   logic          s_req;
   logic          s_we;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_wdata;
   logic          s_gnt;
   logic          s_rvalid;
   logic [DW-1:0] s_rdata;

   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_gnt;
   logic          d_rvalid;
   logic [DW-1:0] d_rdata;

   logic [AW-1:0] m_addr;
   logic          m_we;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;

   modport master (
      output s_req, s_we, s_addr, s_wdata,
      input  s_gnt, s_rvalid, s_rdata,
      output d_req, d_we, d_addr, d_wdata,
      input  d_gnt, d_rvalid, d_rdata,
      input  m_addr, m_we, m_wdata,
      output m_rdata
   );

   modport slave (
      input  s_req, s_we, s_addr, s_wdata,
      output s_gnt, s_rvalid, s_rdata,
      input  d_req, d_we, d_addr, d_wdata,
      output d_gnt, d_rvalid, d_rdata,
      output m_addr, m_we, m_wdata,
      input  m_rdata
   );
endinterface

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Two-requester arbiter for the single-port data memory shared by the sort
// engine (S) and the serial debug unit (D). Grants whole bursts, limits how
// long one side may hold the memory while the other waits, and steers the
// 1-cycle-latency read data back to whichever side issued the read.
//
// Ports
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   bus        dm_arbiter_if.slave: S/D request ports and memory port
//   wait_cnt   16-bit count of cycles in which some requester waited
//   acc_cnt    16-bit count of granted accesses
//   state_dbg  current arbitration state (0 IDLE, 1 OWN_S, 2 OWN_D)
//
// Optional feature: define DM_ARB_STATS_EN to build the statistics counters;
// without it wait_cnt and acc_cnt are tied to zero.
// -----------------------------------------------------------------------------
module dm_arbiter #(
   parameter int AW       = 8,
   parameter int DW       = 32,
   parameter int MAX_HOLD = 16
) (
   input  logic        clk,
   input  logic        rstn,
   dm_arbiter_if.slave bus,
   output logic [15:0] wait_cnt,
   output logic [15:0] acc_cnt,
   output logic [1:0]  state_dbg
);
   localparam int            HW        = $clog2(MAX_HOLD);
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_S = 2'd1,
      OWN_D = 2'd2
   } state_t;

   state_t        state;
   logic [HW-1:0] hold_cnt;
   logic          last_s;     // 1: S was the most recent owner
   logic          tag_s;      // a read for S is in flight
   logic          tag_d;      // a read for D is in flight

   logic          s_gnt;
   logic          d_gnt;
   logic          s_acc;
   logic          d_acc;
   logic          hold_full;
   logic [AW-1:0] mux_addr;
   logic [DW-1:0] mux_wdata;
   logic          mux_we;

   assign s_gnt     = (state == OWN_S);
   assign d_gnt     = (state == OWN_D);
   assign s_acc     = s_gnt & bus.s_req;
   assign d_acc     = d_gnt & bus.d_req;
   assign hold_full = (hold_cnt == HOLD_LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         hold_cnt <= '0;
         last_s   <= 1'b1;
         tag_s    <= 1'b0;
         tag_d    <= 1'b0;
      end else begin
         // The tag follows the issuer, not the owner, so the last read of a
         // preempted burst still returns to its requester.
         tag_s <= s_acc & ~bus.s_we;
         tag_d <= d_acc & ~bus.d_we;
         case (state)
            IDLE: begin
               hold_cnt <= '0;
               if (bus.s_req && bus.d_req) begin
                  if (last_s) begin
                     state  <= OWN_D;
                     last_s <= 1'b0;
                  end else begin
                     state  <= OWN_S;
                     last_s <= 1'b1;
                  end
               end else if (bus.s_req) begin
                  state  <= OWN_S;
                  last_s <= 1'b1;
               end else if (bus.d_req) begin
                  state  <= OWN_D;
                  last_s <= 1'b0;
               end
            end
            OWN_S: begin
               if (!bus.s_req) begin
                  state    <= IDLE;
                  hold_cnt <= '0;
               end else if (bus.d_req && hold_full) begin
                  // Hand over directly, no idle bubble.
                  state    <= OWN_D;
                  last_s   <= 1'b0;
                  hold_cnt <= '0;
               end else if (!hold_full) begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            OWN_D: begin
               if (!bus.d_req) begin
                  state    <= IDLE;
                  hold_cnt <= '0;
               end else if (bus.s_req && hold_full) begin
                  state    <= OWN_S;
                  last_s   <= 1'b1;
                  hold_cnt <= '0;
               end else if (!hold_full) begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            default: begin
               state    <= IDLE;
               hold_cnt <= '0;
            end
         endcase
      end
   end

   // Memory bus follows the owner; everything is zero while idle.
   always_comb begin
      mux_addr  = '0;
      mux_wdata = '0;
      mux_we    = 1'b0;
      if (s_gnt) begin
         mux_addr  = bus.s_addr;
         mux_wdata = bus.s_wdata;
         mux_we    = s_acc & bus.s_we;
      end else if (d_gnt) begin
         mux_addr  = bus.d_addr;
         mux_wdata = bus.d_wdata;
         mux_we    = d_acc & bus.d_we;
      end
   end

   assign bus.m_addr   = mux_addr;
   assign bus.m_wdata  = mux_wdata;
   assign bus.m_we     = mux_we;
   assign bus.s_gnt    = s_gnt;
   assign bus.d_gnt    = d_gnt;
   assign bus.s_rvalid = tag_s;
   assign bus.d_rvalid = tag_d;
   assign bus.s_rdata  = tag_s ? bus.m_rdata : '0;
   assign bus.d_rdata  = tag_d ? bus.m_rdata : '0;
   assign state_dbg    = state;

`ifdef DM_ARB_STATS_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wait_cnt <= '0;
         acc_cnt  <= '0;
      end else begin
         if ((bus.s_req & ~s_gnt) | (bus.d_req & ~d_gnt))
            wait_cnt <= wait_cnt + 16'd1;
         if (s_acc | d_acc)
            acc_cnt <= acc_cnt + 16'd1;
      end
   end
`else
   assign wait_cnt = '0;
   assign acc_cnt  = '0;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
// Self-checking bench for dm_arbiter. A behavioural model tracks owner,
// consecutive-owned-cycle count, last owner, pending read and a reference
// copy of the memory; every cycle the DUT outputs are compared against it.
// Scenario tasks add targeted checks on top.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;
   localparam int MAX_HOLD = 16;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [15:0] wait_cnt;
   logic [15:0] acc_cnt;
   logic [1:0]  state_dbg;

   dm_arbiter_if #(.AW(8), .DW(32)) bus ();

   dm_arbiter #(.AW(8), .DW(32), .MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .bus       (bus),
      .wait_cnt  (wait_cnt),
      .acc_cnt   (acc_cnt),
      .state_dbg (state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- memory (environment) ----------------
   function automatic logic [31:0] mem_init(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {b, ~b, b ^ 8'h5A, 8'hC3};
   endfunction

   logic        mem_loaded = 1'b0;
   logic [31:0] mem [256];

   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= mem_init(i);
         mem_loaded <= 1'b1;
      end else if (bus.m_we) begin
         mem[bus.m_addr] <= bus.m_wdata;
      end
      bus.m_rdata <= mem[bus.m_addr];
   end

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // ---------------- reference model ----------------
   int          m_own;      // 0 none, 1 S, 2 D
   int          m_held;     // completed owned cycles in current grant
   logic        m_last_s;
   int          m_pend;     // 0 none, 1 S, 2 D
   logic [31:0] m_pend_data;
   logic [15:0] m_wait;
   logic [15:0] m_acc;
   logic [31:0] ref_mem [256];

   // snapshot of DUT outputs at the last check point
   logic        sn_sg, sn_dg, sn_sv, sn_dv, sn_mwe;
   logic [31:0] sn_srd;
   logic [15:0] sn_wait, sn_acc;

   task automatic model_reset();
      m_own = 0; m_held = 0; m_last_s = 1'b1; m_pend = 0;
      m_pend_data = '0; m_wait = '0; m_acc = '0;
   endtask

   task automatic set_inputs(input logic sr, input logic swe, input logic [7:0] sa,
                             input logic [31:0] swd, input logic dr, input logic dwe,
                             input logic [7:0] da, input logic [31:0] dwd);
      bus.s_req = sr; bus.s_we = swe; bus.s_addr = sa; bus.s_wdata = swd;
      bus.d_req = dr; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dwd;
   endtask

   // One clock cycle: drive, check against the model, advance the model.
   // Called at a falling edge, returns at the next falling edge.
   task automatic run_cycle(input logic sr, input logic swe, input logic [7:0] sa,
                            input logic [31:0] swd, input logic dr, input logic dwe,
                            input logic [7:0] da, input logic [31:0] dwd);
      logic        e_mwe;
      logic [7:0]  e_ma;
      logic [31:0] e_mwd, e_srd, e_drd;
      logic [15:0] e_wait, e_acc;
      int          nxt, new_pend;
      set_inputs(sr, swe, sa, swd, dr, dwe, da, dwd);
      #1;
      e_mwe = ((m_own == 1) && sr && swe) || ((m_own == 2) && dr && dwe);
      e_ma  = (m_own == 1) ? sa  : (m_own == 2) ? da  : 8'h00;
      e_mwd = (m_own == 1) ? swd : (m_own == 2) ? dwd : 32'h0;
      e_srd = (m_pend == 1) ? m_pend_data : 32'h0;
      e_drd = (m_pend == 2) ? m_pend_data : 32'h0;
`ifdef DM_ARB_STATS_EN
      e_wait = m_wait; e_acc = m_acc;
`else
      e_wait = 16'h0;  e_acc = 16'h0;
`endif
      sn_sg = bus.s_gnt; sn_dg = bus.d_gnt; sn_sv = bus.s_rvalid; sn_dv = bus.d_rvalid;
      sn_mwe = bus.m_we; sn_srd = bus.s_rdata; sn_wait = wait_cnt; sn_acc = acc_cnt;

      checks++;
      if ({bus.s_gnt, bus.d_gnt} !== {m_own == 1, m_own == 2}) begin
         errors++;
         $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, {bus.s_gnt, bus.d_gnt}, {m_own == 1, m_own == 2});
      end
      checks++;
      if ({bus.s_rvalid, bus.d_rvalid} !== {m_pend == 1, m_pend == 2}) begin
         errors++;
         $display("FAIL rvalid cyc=%0d got=%b exp=%b", cyc, {bus.s_rvalid, bus.d_rvalid}, {m_pend == 1, m_pend == 2});
      end
      checks++;
      if ({bus.s_rdata, bus.d_rdata} !== {e_srd, e_drd}) begin
         errors++;
         $display("FAIL rdata cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.s_rdata, bus.d_rdata, e_srd, e_drd);
      end
      checks++;
      if ({bus.m_we, bus.m_addr, bus.m_wdata} !== {e_mwe, e_ma, e_mwd}) begin
         errors++;
         $display("FAIL mem_bus cyc=%0d got=%b/%h/%h exp=%b/%h/%h", cyc, bus.m_we, bus.m_addr, bus.m_wdata, e_mwe, e_ma, e_mwd);
      end
      checks++;
      if ({wait_cnt, acc_cnt} !== {e_wait, e_acc}) begin
         errors++;
         $display("FAIL stats cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, wait_cnt, acc_cnt, e_wait, e_acc);
      end

      // advance model by one clock
      new_pend = 0;
      if (m_own == 1 && sr) begin
         m_acc = m_acc + 16'd1;
         if (swe) ref_mem[sa] = swd;
         else begin new_pend = 1; m_pend_data = ref_mem[sa]; end
      end
      if (m_own == 2 && dr) begin
         m_acc = m_acc + 16'd1;
         if (dwe) ref_mem[da] = dwd;
         else begin new_pend = 2; m_pend_data = ref_mem[da]; end
      end
      if ((sr && m_own != 1) || (dr && m_own != 2)) m_wait = m_wait + 16'd1;
      m_pend = new_pend;
      case (m_own)
         0: nxt = (sr && dr) ? (m_last_s ? 2 : 1) : sr ? 1 : dr ? 2 : 0;
         1: nxt = !sr ? 0 : (dr && m_held >= MAX_HOLD - 1) ? 2 : 1;
         default: nxt = !dr ? 0 : (sr && m_held >= MAX_HOLD - 1) ? 1 : 2;
      endcase
      if (nxt != 0 && nxt == m_own) m_held++;
      else m_held = 0;
      if (nxt != 0 && nxt != m_own) m_last_s = (nxt == 1);
      m_own = nxt;
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      set_inputs(0, 0, 8'h0, 32'h0, 0, 0, 8'h0, 32'h0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if ({bus.s_gnt, bus.d_gnt, bus.s_rvalid, bus.d_rvalid, bus.m_we} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl got=%b exp=00000", {bus.s_gnt, bus.d_gnt, bus.s_rvalid, bus.d_rvalid, bus.m_we});
      end
      checks++;
      if ({bus.m_addr, bus.m_wdata, wait_cnt, acc_cnt} !== 72'h0) begin
         errors++;
         $display("FAIL reset_data got=%h/%h/%0d/%0d exp=0", bus.m_addr, bus.m_wdata, wait_cnt, acc_cnt);
      end
      rstn = 1'b1;
      @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(i);
      do_reset();
   endtask

   task automatic test_s_only();
      int issued = 0, rv_cnt = 0, d_noise = 0;
      logic sr, granted;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         sr = (issued < 3);
         granted = (m_own == 1);
         run_cycle(sr, 0, 8'(8'h10 + issued), 32'h0, 0, 0, 8'h0, 32'h0);
         if (i == 0 || i == 1) begin
            checks++;
            if (sn_sg !== (i == 1)) begin
               errors++;
               $display("FAIL s_gnt_latency i=%0d got=%b exp=%b", i, sn_sg, i == 1);
            end
         end
         if (sn_sv) begin
            checks++;
            if (sn_srd !== ref_mem[8'(8'h10 + rv_cnt)]) begin
               errors++;
               $display("FAIL s_only_data n=%0d got=%h exp=%h", rv_cnt, sn_srd, ref_mem[8'(8'h10 + rv_cnt)]);
            end
            rv_cnt++;
         end
         if (sn_dg || sn_dv) d_noise++;
         if (granted && sr) issued++;
      end
      checks++;
      if (rv_cnt != 3 || d_noise != 0 || sn_sg !== 1'b0) begin
         errors++;
         $display("FAIL s_only_summary got=rv%0d/dn%0d/sg%b exp=rv3/dn0/sg0", rv_cnt, d_noise, sn_sg);
      end
   endtask

   task automatic test_tie();
      logic s_after = 1'b0;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         run_cycle(1, 0, 8'(i), 32'h0, i < 5, 0, 8'(8'h60 + i), 32'h0);
         if (i == 1) begin
            checks++;
            if ({sn_sg, sn_dg} !== 2'b01) begin
               errors++;
               $display("FAIL tie_first got=%b exp=01", {sn_sg, sn_dg});
            end
         end
         if (i >= 5 && sn_sg) s_after = 1'b1;
      end
      checks++;
      if (s_after !== 1'b1) begin
         errors++;
         $display("FAIL tie_s_regrant got=%b exp=1", s_after);
      end
   endtask

   task automatic test_starvation();
      int s_cnt1 = 0, stint = 0, tag_hits = 0;
      logic s_regrant = 1'b0, prev_tag = 1'b0, tag_cycle, sr, dr;
      logic [7:0] sa;
      do_reset();
      for (int i = 0; i < 60; i++) begin
         sr = (i < 40);
         dr = (i >= 5 && i < 25);
         tag_cycle = (m_own == 1 && m_held == MAX_HOLD - 1 && dr);
         sa = tag_cycle ? 8'h20 : 8'(8'h40 + i);
         run_cycle(sr, 0, sa, 32'h0, dr, 0, 8'(8'h80 + i), 32'h0);
         if (prev_tag) begin
            tag_hits++;
            checks++;
            if ({sn_sv, sn_dg, sn_dv} !== 3'b110 || sn_srd !== ref_mem[8'h20]) begin
               errors++;
               $display("FAIL switch_tag got=%b/%h exp=110/%h", {sn_sv, sn_dg, sn_dv}, sn_srd, ref_mem[8'h20]);
            end
         end
         prev_tag = tag_cycle;
         if (stint == 0 && sn_sg) s_cnt1++;
         else if (stint == 0 && s_cnt1 > 0) begin
            stint = 1;
            checks++;
            if (sn_dg !== 1'b1) begin
               errors++;
               $display("FAIL no_bubble got=%b exp=1", sn_dg);
            end
         end else if (stint == 1 && sn_sg) s_regrant = 1'b1;
      end
      checks++;
      if (s_cnt1 != MAX_HOLD) begin
         errors++;
         $display("FAIL hold_limit got=%0d exp=%0d", s_cnt1, MAX_HOLD);
      end
      checks++;
      if (s_regrant !== 1'b1 || tag_hits != 1) begin
         errors++;
         $display("FAIL s_regrant got=%b/%0d exp=1/1", s_regrant, tag_hits);
      end
   endtask

   task automatic test_write_readback();
      logic wdone = 1'b0, rdone = 1'b0, g_s, g_d, sr, dr;
      int rseen = 0, idle_we = 0;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         g_s = (m_own == 1);
         g_d = (m_own == 2);
         dr = !wdone;
         sr = wdone && !rdone;
         run_cycle(sr, 0, 8'h05, 32'h0, dr, 1, 8'h05, 32'hDEADBEEF);
         if (sn_sv) begin
            rseen++;
            checks++;
            if (sn_srd !== 32'hDEADBEEF) begin
               errors++;
               $display("FAIL readback got=%h exp=deadbeef", sn_srd);
            end
         end
         if (sn_mwe && !sn_sg && !sn_dg) idle_we++;
         if (g_d && dr) wdone = 1'b1;
         if (g_s && sr) rdone = 1'b1;
      end
      checks++;
      if (rseen != 1 || idle_we != 0) begin
         errors++;
         $display("FAIL wr_summary got=rv%0d/iw%0d exp=rv1/iw0", rseen, idle_we);
      end
   endtask

   task automatic test_stats_reset();
      logic [15:0] e_w, e_a;
      do_reset();
      for (int i = 0; i < 13; i++)
         run_cycle(i <= 10, 0, 8'(i), 32'h0, i >= 2 && i <= 4, 0, 8'h0, 32'h0);
`ifdef DM_ARB_STATS_EN
      e_w = 16'd4; e_a = 16'd10;
`else
      e_w = 16'd0; e_a = 16'd0;
`endif
      checks++;
      if ({sn_wait, sn_acc} !== {e_w, e_a}) begin
         errors++;
         $display("FAIL stats_totals got=%0d/%0d exp=%0d/%0d", sn_wait, sn_acc, e_w, e_a);
      end
      for (int i = 0; i < 4; i++)
         run_cycle(1, 0, 8'(8'h30 + i), 32'h0, 0, 0, 8'h0, 32'h0);
      checks++;
      if ({sn_sg, bus.s_rvalid} !== 2'b11) begin
         errors++;
         $display("FAIL burst_active got=%b exp=11", {sn_sg, bus.s_rvalid});
      end
      rstn = 1'b0;
      #1;
      checks++;
      if ({bus.s_gnt, bus.d_gnt, bus.s_rvalid, bus.d_rvalid, bus.m_we} !== 5'b0 ||
          {bus.s_rdata, wait_cnt, acc_cnt} !== 64'h0) begin
         errors++;
         $display("FAIL midburst_reset got=%b/%h/%0d/%0d exp=0", {bus.s_gnt, bus.d_gnt, bus.s_rvalid, bus.d_rvalid, bus.m_we},
                  bus.s_rdata, wait_cnt, acc_cnt);
      end
      model_reset();
      set_inputs(0, 0, 8'h0, 32'h0, 0, 0, 8'h0, 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_random();
      logic sr = 1'b0, dr = 1'b0;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) sr = ~sr;
         if ($urandom_range(0, 7) == 0) dr = ~dr;
         run_cycle(sr, $urandom_range(0, 2) == 0, 8'($urandom_range(0, 255)), $urandom,
                   dr, $urandom_range(0, 2) == 0, 8'($urandom_range(0, 255)), $urandom);
      end
   endtask

   // ---------------- main ----------------
   initial begin
      set_inputs(0, 0, 8'h0, 32'h0, 0, 0, 8'h0, 32'h0);
      @(negedge clk);
      test_reset();
      test_s_only();
      test_tie();
      test_starvation();
      test_write_readback();
      test_stats_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
